// File: rtl/haui_gpio_bank.sv
// haui_gpio_bank: Wishbone classic slave GPIO bank with synchronised pad
// inputs, per-pin polarity-selectable edge detection, sticky W1C status
// flags, a saturating edge-event counter and registered level interrupts.
module haui_gpio_bank #(
    parameter int          NUM_IO      = 16,
    parameter int          NUM_IRQ     = 3,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic [NUM_IO-1:0]  io_in,
    output logic [NUM_IO-1:0]  io_out,
    output logic [NUM_IO-1:0]  io_oeb,
    output logic [NUM_IRQ-1:0] irq
);

    localparam logic [5:0] IDX_OUT  = 6'h00;
    localparam logic [5:0] IDX_OEB  = 6'h01;
    localparam logic [5:0] IDX_IN   = 6'h02;
    localparam logic [5:0] IDX_IE   = 6'h03;
    localparam logic [5:0] IDX_POL  = 6'h04;
    localparam logic [5:0] IDX_STAT = 6'h05;
    localparam logic [5:0] IDX_CNT  = 6'h06;

    localparam logic [NUM_IO-1:0] ALL_ONES  = '1;
    localparam logic [2:0]        SUPP_INIT = 3'(SYNC_STAGES + 1);

    // Bus decode
    logic              hit;
    logic              accept;
    logic              wr_en;
    logic [5:0]        reg_idx;
    logic [NUM_IO-1:0] wmask;
    logic [NUM_IO-1:0] wdata;
    logic [31:0]       rd_data;

    // Architectural state
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [NUM_IO-1:0] out_q, out_d;
    logic [NUM_IO-1:0] oeb_q, oeb_d;
    logic [NUM_IO-1:0] ie_q, ie_d;
    logic [NUM_IO-1:0] pol_q, pol_d;
    logic [NUM_IO-1:0] stat_q, stat_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;

    // Input path
    logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IO-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IO-1:0] prev_q, prev_d;
    logic [2:0]        supp_q, supp_d;
    logic [NUM_IO-1:0] sync_in;
    logic [NUM_IO-1:0] edge_evt;
    logic [5:0]        edge_cnt;

    // Write side helpers
    logic [NUM_IO-1:0] stat_clr;
    logic              cnt_clr;
    logic [16:0]       cnt_sum;

    // Address bits [1:0] and the bus lanes above NUM_IO are deliberately ignored
    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i, wbs_dat_i};

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign reg_idx = wbs_adr_i[7:2];
    assign accept  = hit & ~ack_q;
    assign wr_en   = accept & wbs_we_i;
    assign wdata   = wbs_dat_i[NUM_IO-1:0];
    assign sync_in = sync_q[SYNC_STAGES-1];

    // Expand byte-lane selects into a per-pin write mask
    always_comb begin
        wmask = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            wmask[i] = wbs_sel_i[2'(i / 8)];
        end
    end

    // Synchroniser chain, previous-sample flop and post-reset edge suppression
    always_comb begin
        sync_d[0] = io_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_in;
        supp_d = (supp_q == 3'd0) ? 3'd0 : supp_q - 3'd1;
    end

    // Polarity-selected edge detection and count of edges this cycle
    always_comb begin
        edge_evt = '0;
        if (supp_q == 3'd0) begin
            edge_evt = (pol_q & sync_in & ~prev_q) | (~pol_q & ~sync_in & prev_q);
        end
        edge_cnt = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            edge_cnt = edge_cnt + {5'd0, edge_evt[i]};
        end
    end

    // Register writes, sticky status with set-over-clear, saturating counter
    always_comb begin
        out_d    = out_q;
        oeb_d    = oeb_q;
        ie_d     = ie_q;
        pol_d    = pol_q;
        stat_clr = '0;
        cnt_clr  = 1'b0;
        if (wr_en) begin
            case (reg_idx)
                IDX_OUT:  out_d    = (out_q & ~wmask) | (wdata & wmask);
                IDX_OEB:  oeb_d    = (oeb_q & ~wmask) | (wdata & wmask);
                IDX_IE:   ie_d     = (ie_q  & ~wmask) | (wdata & wmask);
                IDX_POL:  pol_d    = (pol_q & ~wmask) | (wdata & wmask);
                IDX_STAT: stat_clr = wdata & wmask;
                IDX_CNT:  cnt_clr  = |wbs_sel_i;
                default:  ;
            endcase
        end
        stat_d  = (stat_q & ~stat_clr) | edge_evt;
        cnt_sum = {1'b0, cnt_q} + {11'd0, edge_cnt};
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    // Read mux; data is registered alongside ack and is zero otherwise
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            IDX_OUT:  rd_data = 32'(out_q);
            IDX_OEB:  rd_data = 32'(oeb_q);
            IDX_IN:   rd_data = 32'(sync_in);
            IDX_IE:   rd_data = 32'(ie_q);
            IDX_POL:  rd_data = 32'(pol_q);
            IDX_STAT: rd_data = 32'(stat_q);
            IDX_CNT:  rd_data = 32'(cnt_q) & 32'(ALL_ONES);
            default:  rd_data = '0;
        endcase
        ack_d = accept;
        dat_d = accept ? rd_data : 32'd0;
    end

    // Interrupt k collects enabled status of pins i with i mod NUM_IRQ == k
    always_comb begin
        irq_d = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            for (int i = 0; i < NUM_IO; i++) begin
                if ((i % NUM_IRQ) == k) begin
                    irq_d[k] = irq_d[k] | (stat_q[i] & ie_q[i]);
                end
            end
        end
    end

    // State registers with synchronous reset; reset also aborts any bus cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
            supp_q <= SUPP_INIT;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            out_q  <= '0;
            oeb_q  <= ALL_ONES;
            ie_q   <= '0;
            pol_q  <= ALL_ONES;
            stat_q <= '0;
            cnt_q  <= '0;
            irq_q  <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q <= prev_d;
            supp_q <= supp_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            out_q  <= out_d;
            oeb_q  <= oeb_d;
            ie_q   <= ie_d;
            pol_q  <= pol_d;
            stat_q <= stat_d;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = out_q;
    assign io_oeb    = oeb_q;
    assign irq       = irq_q;

endmodule
